inst_fetch_ctl: RTL and testbench

Parametrised program-counter controller for the lab CPU fetch stage. It generalises the single-program fetch unit with the following additions:
- a configurable PC width
- selectable program start addresses
- a pipeline stall
- signed relative branches
- a hardware call/return stack with overflow and underflow reporting

It drives instruction-ROM addressing from branch and control decode and ALU flag inputs.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/ret_stack.sv | 72 +++++++
 rtl/inst_fetch_ctl.sv | 134 +++++++++++++
 tb/tb_inst_fetch_ctl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch controller: default PC width,
// default return-stack depth, default program start addresses, and the
// next-PC source selector produced by the controller's priority encoder.
// ----------------------------------------------------------------------------
package fetch_pkg;

    localparam int unsigned PC_W_DEFAULT        = 10;
    localparam int unsigned STACK_DEPTH_DEFAULT = 4;

    localparam int unsigned START0_DEFAULT = 'h000;
    localparam int unsigned START1_DEFAULT = 'h100;
    localparam int unsigned START2_DEFAULT = 'h200;
    localparam int unsigned START3_DEFAULT = 'h300;

    // Next-PC source, in decreasing priority order after NPC_HOLD/NPC_START.
    typedef enum logic [2:0] {
        NPC_HOLD,
        NPC_START,
        NPC_RET,
        NPC_CALL,
        NPC_ABS,
        NPC_REL,
        NPC_INC
    } npc_sel_t;

endpackage

// File: rtl/ret_stack.sv
// ----------------------------------------------------------------------------
// ret_stack
// Hardware call/return LIFO for the fetch controller.
//   Clk    : rising-edge clock
//   Reset  : asynchronous active-low reset (empties stack, zeroes entries)
//   push   : write din on top (ignored when full)
//   pop    : drop top entry (ignored when empty)
//   clear  : empty the stack and zero all entries (dominates push/pop)
//   din    : value to push
//   top    : most recently pushed entry (undefined content when empty)
//   count  : number of occupied entries
//   full   : count == STACK_DEPTH
//   empty  : count == 0
// ----------------------------------------------------------------------------
module ret_stack #(
    parameter int unsigned PC_W        = 10,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           clear,
    input  logic [PC_W-1:0]                din,
    output logic [PC_W-1:0]                top,
    output logic [$clog2(STACK_DEPTH):0]   count,
    output logic                           full,
    output logic                           empty
);

    localparam int unsigned AW = $clog2(STACK_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [PC_W-1:0] mem [STACK_DEPTH];
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   top_idx;

    // Depth is a power of two, so the low count bits address the next free
    // slot whenever the stack is not full.
    assign wr_idx  = cnt[AW-1:0];
    assign top_idx = cnt[AW-1:0] - AW'(1);

    assign top   = mem[top_idx];
    assign count = cnt;
    assign full  = (cnt == CW'(STACK_DEPTH));
    assign empty = (cnt == '0);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt <= '0;
            for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            cnt <= '0;
            for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (pop) begin
            if (!empty) begin
                cnt <= cnt - CW'(1);
            end
        end else if (push) begin
            if (!full) begin
                mem[wr_idx] <= din;
                cnt         <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/inst_fetch_ctl.sv
// ----------------------------------------------------------------------------
// inst_fetch_ctl
// Program-counter controller for the CPU fetch stage.
//   Clk         : rising-edge clock
//   Reset       : asynchronous active-low reset (PC = START0, stack empty)
//   Start       : load and hold the start address selected by ProgSel
//   ProgSel     : program select (0..3)
//   Stall       : hold PC, stack and flags
//   BranchAbs   : jump to Target
//   BranchRelEn : relative branch by signed Target when ALU_flag is high
//   ALU_flag    : branch condition
//   Call        : push PC+1, jump to Target
//   Ret         : pop stack into PC
//   Target      : absolute address or two's-complement offset
//   ProgCtr     : current program counter (registered)
//   StackCnt    : occupied return-stack entries
//   StackOvf    : sticky, push attempted while full
//   StackUnf    : sticky, pop attempted while empty
// ----------------------------------------------------------------------------
module inst_fetch_ctl
    import fetch_pkg::*;
#(
    parameter int unsigned PC_W        = PC_W_DEFAULT,
    parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEFAULT,
    parameter int unsigned START0      = START0_DEFAULT,
    parameter int unsigned START1      = START1_DEFAULT,
    parameter int unsigned START2      = START2_DEFAULT,
    parameter int unsigned START3      = START3_DEFAULT
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           Start,
    input  logic [1:0]                     ProgSel,
    input  logic                           Stall,
    input  logic                           BranchAbs,
    input  logic                           BranchRelEn,
    input  logic                           ALU_flag,
    input  logic                           Call,
    input  logic                           Ret,
    input  logic [PC_W-1:0]                Target,
    output logic [PC_W-1:0]                ProgCtr,
    output logic [$clog2(STACK_DEPTH):0]   StackCnt,
    output logic                           StackOvf,
    output logic                           StackUnf
);

    npc_sel_t        sel;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] start_addr;
    logic [PC_W-1:0] stk_top;
    logic            stk_full;
    logic            stk_empty;
    logic            stk_push;
    logic            stk_pop;
    logic            stk_clear;

    assign pc_inc = ProgCtr + PC_W'(1);

    always_comb begin
        start_addr = PC_W'(START0);
        case (ProgSel)
            2'd0:    start_addr = PC_W'(START0);
            2'd1:    start_addr = PC_W'(START1);
            2'd2:    start_addr = PC_W'(START2);
            default: start_addr = PC_W'(START3);
        endcase
    end

    // Priority encoder: Start over Stall over Ret over Call over branches.
    always_comb begin
        sel = NPC_INC;
        if (Start)                         sel = NPC_START;
        else if (Stall)                    sel = NPC_HOLD;
        else if (Ret)                      sel = NPC_RET;
        else if (Call)                     sel = NPC_CALL;
        else if (BranchAbs)                sel = NPC_ABS;
        else if (BranchRelEn && ALU_flag)  sel = NPC_REL;
    end

    always_comb begin
        pc_next = pc_inc;
        case (sel)
            NPC_HOLD:  pc_next = ProgCtr;
            NPC_START: pc_next = start_addr;
            NPC_RET:   pc_next = stk_empty ? pc_inc : stk_top;
            NPC_CALL:  pc_next = Target;
            NPC_ABS:   pc_next = Target;
            // Unsigned add of the raw offset equals signed add modulo 2^PC_W.
            NPC_REL:   pc_next = ProgCtr + Target;
            NPC_INC:   pc_next = pc_inc;
            default:   pc_next = pc_inc;
        endcase
    end

    // The stack refuses out-of-range operations itself; only the flags here.
    assign stk_push  = (sel == NPC_CALL);
    assign stk_pop   = (sel == NPC_RET);
    assign stk_clear = (sel == NPC_START);

    ret_stack #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .Clk   (Clk),
        .Reset (Reset),
        .push  (stk_push),
        .pop   (stk_pop),
        .clear (stk_clear),
        .din   (pc_inc),
        .top   (stk_top),
        .count (StackCnt),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ProgCtr  <= PC_W'(START0);
            StackOvf <= 1'b0;
            StackUnf <= 1'b0;
        end else begin
            ProgCtr <= pc_next;
            if (sel == NPC_START) begin
                StackOvf <= 1'b0;
                StackUnf <= 1'b0;
            end else begin
                if (stk_push && stk_full)  StackOvf <= 1'b1;
                if (stk_pop && stk_empty)  StackUnf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctl.sv
module tb_inst_fetch_ctl;

    localparam int unsigned PW = 10;
    localparam int unsigned CW = 3;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Start;
    logic [1:0]    ProgSel;
    logic          Stall;
    logic          BranchAbs;
    logic          BranchRelEn;
    logic          ALU_flag;
    logic          Call;
    logic          Ret;
    logic [PW-1:0] Target;
    logic [PW-1:0] ProgCtr;
    logic [CW-1:0] StackCnt;
    logic          StackOvf;
    logic          StackUnf;

    typedef struct packed {
        logic [PW-1:0] pc;
        logic [CW-1:0] cnt;
        logic          ovf;
        logic          unf;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    inst_fetch_ctl #(
        .PC_W        (PW),
        .STACK_DEPTH (4),
        .START0      ('h000),
        .START1      ('h100),
        .START2      ('h200),
        .START3      ('h300)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .ProgSel     (ProgSel),
        .Stall       (Stall),
        .BranchAbs   (BranchAbs),
        .BranchRelEn (BranchRelEn),
        .ALU_flag    (ALU_flag),
        .Call        (Call),
        .Ret         (Ret),
        .Target      (Target),
        .ProgCtr     (ProgCtr),
        .StackCnt    (StackCnt),
        .StackOvf    (StackOvf),
        .StackUnf    (StackUnf)
    );

    always #5 Clk = ~Clk;

    task automatic push_exp(input string tag, input logic [PW-1:0] pc,
                            input logic [CW-1:0] cnt, input logic ovf, input logic unf);
        obs_t e;
        e.pc  = pc;
        e.cnt = cnt;
        e.ovf = ovf;
        e.unf = unf;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic compare_head();
        obs_t  e;
        obs_t  o;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o.pc  = ProgCtr;
        o.cnt = StackCnt;
        o.ovf = StackOvf;
        o.unf = StackUnf;
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed pc=%h cnt=%0d ovf=%b unf=%b, expected pc=%h cnt=%0d ovf=%b unf=%b",
                   t, o.pc, o.cnt, o.ovf, o.unf, e.pc, e.cnt, e.ovf, e.unf);
        end
    endtask

    // One clock: expectation queued with the stimulus, checked 1 time unit after the edge.
    task automatic step(input string tag, input logic [PW-1:0] pc,
                        input logic [CW-1:0] cnt, input logic ovf, input logic unf);
        push_exp(tag, pc, cnt, ovf, unf);
        @(posedge Clk);
        #1;
        compare_head();
    endtask

    task automatic check_now(input string tag, input logic [PW-1:0] pc,
                             input logic [CW-1:0] cnt, input logic ovf, input logic unf);
        push_exp(tag, pc, cnt, ovf, unf);
        compare_head();
    endtask

    task automatic idle();
        Start       = 1'b0;
        ProgSel     = 2'd0;
        Stall       = 1'b0;
        BranchAbs   = 1'b0;
        BranchRelEn = 1'b0;
        ALU_flag    = 1'b0;
        Call        = 1'b0;
        Ret         = 1'b0;
        Target      = '0;
    endtask

    task automatic jump(input logic [PW-1:0] t);
        idle(); BranchAbs = 1'b1; Target = t;
    endtask

    task automatic do_call(input logic [PW-1:0] t);
        idle(); Call = 1'b1; Target = t;
    endtask

    task automatic do_ret();
        idle(); Ret = 1'b1;
    endtask

    initial begin
        // Reset low with every input high
        Reset = 1'b0; Start = 1'b1; ProgSel = 2'b11; Stall = 1'b1; BranchAbs = 1'b1;
        BranchRelEn = 1'b1; ALU_flag = 1'b1; Call = 1'b1; Ret = 1'b1; Target = '1;
        #3;
        check_now("reset_async", 'h000, 0, 0, 0);
        @(posedge Clk); #1;
        check_now("reset_held", 'h000, 0, 0, 0);

        // Start program 2 for three cycles, then release
        Reset = 1'b1;
        idle(); Start = 1'b1; ProgSel = 2'd2;
        step("start_a", 'h200, 0, 0, 0);
        step("start_b", 'h200, 0, 0, 0);
        step("start_c", 'h200, 0, 0, 0);
        idle();
        step("post_start_1", 'h201, 0, 0, 0);
        step("post_start_2", 'h202, 0, 0, 0);

        // Branches
        jump('h010);             step("abs_010", 'h010, 0, 0, 0);
        jump('h011);             step("abs_011", 'h011, 0, 0, 0);
        idle(); BranchRelEn = 1'b1; ALU_flag = 1'b0; Target = 'h005;
        step("rel_not_taken", 'h012, 0, 0, 0);
        ALU_flag = 1'b1;
        step("rel_fwd", 'h017, 0, 0, 0);
        Target = 'h3FE;
        step("rel_back", 'h015, 0, 0, 0);
        jump('h3FF);             step("abs_3ff", 'h3FF, 0, 0, 0);
        idle(); BranchRelEn = 1'b1; ALU_flag = 1'b1; Target = 'h001;
        step("rel_wrap", 'h000, 0, 0, 0);
        jump('h3FF);             step("abs_3ff_b", 'h3FF, 0, 0, 0);
        idle();                  step("inc_wrap", 'h000, 0, 0, 0);

        // Call/return nesting
        jump('h020);             step("abs_020", 'h020, 0, 0, 0);
        do_call('h100);          step("call_1", 'h100, 1, 0, 0);
        do_call('h180);          step("call_2", 'h180, 2, 0, 0);
        do_ret();                step("ret_1", 'h101, 1, 0, 0);
        do_ret();                step("ret_2", 'h021, 0, 0, 0);

        // Overflow: pushes 022, 041, 051, 061; fifth call refused
        do_call('h040);          step("fill_1", 'h040, 1, 0, 0);
        do_call('h050);          step("fill_2", 'h050, 2, 0, 0);
        do_call('h060);          step("fill_3", 'h060, 3, 0, 0);
        do_call('h070);          step("fill_4", 'h070, 4, 0, 0);
        do_call('h080);          step("ovf_call", 'h080, 4, 1, 0);
        do_ret();                step("drain_1", 'h061, 3, 1, 0);
        do_ret();                step("drain_2", 'h051, 2, 1, 0);
        do_ret();                step("drain_3", 'h041, 1, 1, 0);
        do_ret();                step("drain_4", 'h022, 0, 1, 0);
        do_ret();                step("unf_ret", 'h023, 0, 1, 1);
        idle();                  step("sticky", 'h024, 0, 1, 1);
        idle(); Start = 1'b1; ProgSel = 2'd1;
        step("start_clears", 'h100, 0, 0, 0);

        // Pushed return address wraps
        jump('h3FF);             step("abs_3ff_c", 'h3FF, 0, 0, 0);
        do_call('h010);          step("call_at_top", 'h010, 1, 0, 0);
        do_ret();                step("ret_wrapped", 'h000, 0, 0, 0);

        // Priority
        jump('h101);             step("abs_101", 'h101, 0, 0, 0);
        do_call('h200);          step("call_pre", 'h200, 1, 0, 0);
        idle(); Call = 1'b1; Ret = 1'b1; Target = 'h300;
        step("call_ret_both", 'h102, 0, 0, 0);
        idle(); Call = 1'b1; BranchAbs = 1'b1; Target = 'h050;
        step("call_over_abs", 'h050, 1, 0, 0);
        do_ret();                step("ret_after_abs", 'h103, 0, 0, 0);
        idle(); Stall = 1'b1; BranchAbs = 1'b1; Target = 'h1AA;
        step("stall_abs", 'h103, 0, 0, 0);
        do_call('h060);          step("call_pre2", 'h060, 1, 0, 0);
        idle(); Stall = 1'b1; Ret = 1'b1;
        step("stall_ret", 'h060, 1, 0, 0);
        do_ret();                step("ret_after_stall", 'h104, 0, 0, 0);
        idle(); Start = 1'b1; Stall = 1'b1; ProgSel = 2'd3;
        step("start_over_stall", 'h300, 0, 0, 0);
        idle();                  step("post_start3", 'h301, 0, 0, 0);

        // Asynchronous reset with three entries stacked
        do_call('h010);          step("deep_1", 'h010, 1, 0, 0);
        do_call('h020);          step("deep_2", 'h020, 2, 0, 0);
        do_call('h030);          step("deep_3", 'h030, 3, 0, 0);
        idle();
        #2 Reset = 1'b0;
        #1 check_now("async_reset", 'h000, 0, 0, 0);
        #1 Reset = 1'b1;
        step("after_reset", 'h001, 0, 0, 0);
        do_ret();                step("stack_discarded", 'h002, 0, 0, 1);

        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_drain: observed %0d pending, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
